// File: rtl/stream_frame_aligner.sv
// Frame aligner: discards pixels until a start-of-frame, enforces a fixed frame
// length, regenerates eop, flags short/long frames, and buffers output in a show-ahead FIFO.
module stream_frame_aligner #(
    parameter int DEPTH        = 16,
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] data_in,
    input  logic        sop_in,
    input  logic        eop_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        ready_in,
    output logic [11:0] data_out,
    output logic        sop_out,
    output logic        eop_out,
    output logic        valid_out,
    output logic [15:0] frame_count,
    output logic        short_err,
    output logic        long_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [AW:0]      DEPTH_OCC = (AW + 1)'(DEPTH);

    typedef enum logic {
        SEEK,
        PASS
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               short_reg, short_next;
    logic               long_reg, long_next;
    logic               wr_en, wr_sop, wr_eop;

    logic [13:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]        occ_reg;
    logic [15:0]        frame_count_reg;
    logic               full, empty, accept, push, pop;
    logic [13:0]        head;

    assign full      = (occ_reg == DEPTH_OCC);
    assign empty     = (occ_reg == '0);
    assign ready_out = !full && !reset;
    assign accept    = valid_in && ready_out;
    assign push      = wr_en;
    assign pop       = !empty && ready_in;

    assign head        = mem[rd_ptr_reg];
    assign data_out    = head[13:2];
    assign sop_out     = head[1];
    assign eop_out     = head[0];
    assign valid_out   = !empty;
    assign frame_count = frame_count_reg;
    assign short_err   = short_reg;
    assign long_err    = long_reg;

    // Framing decisions are made only on accepted beats; sop takes priority over eop.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        wr_en      = 1'b0;
        wr_sop     = 1'b0;
        wr_eop     = 1'b0;
        short_next = 1'b0;
        long_next  = 1'b0;
        if (accept) begin
            unique case (state_reg)
                SEEK: begin
                    if (sop_in) begin
                        wr_en  = 1'b1;
                        wr_sop = 1'b1;
                        if (FRAME_PIXELS == 1) begin
                            wr_eop = 1'b1;
                        end else begin
                            count_next = CNT_W'(1);
                            state_next = PASS;
                        end
                    end
                end
                PASS: begin
                    wr_en = 1'b1;
                    if (sop_in) begin
                        wr_sop     = 1'b1;
                        short_next = 1'b1;
                        count_next = CNT_W'(1);
                    end else if (count_reg == LAST_PIX) begin
                        wr_eop     = 1'b1;
                        long_next  = !eop_in;
                        count_next = '0;
                        state_next = SEEK;
                    end else if (eop_in) begin
                        wr_eop     = 1'b1;
                        short_next = 1'b1;
                        count_next = '0;
                        state_next = SEEK;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
                default: state_next = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SEEK;
            count_reg <= '0;
            short_reg <= 1'b0;
            long_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            short_reg <= short_next;
            long_reg  <= long_next;
        end
    end

    // Storage carries no reset; validity is tracked by the occupancy counter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {data_in, wr_sop, wr_eop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            occ_reg         <= '0;
            frame_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                if (head[0]) begin
                    frame_count_reg <= frame_count_reg + 16'd1;
                end
            end
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + (AW + 1)'(1);
                2'b01:   occ_reg <= occ_reg - (AW + 1)'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_frame_aligner.sv
// Directed bench for stream_frame_aligner with FRAME_PIXELS=8, DEPTH=4.
module tb_stream_frame_aligner;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] data_in;
    logic        sop_in, eop_in, valid_in;
    logic        ready_out;
    logic        ready_in;
    logic [11:0] data_out;
    logic        sop_out, eop_out, valid_out;
    logic [15:0] frame_count;
    logic        short_err, long_err;

    int tests_run = 0;
    int tests_failed = 0;
    int short_cnt = 0;
    int long_cnt = 0;
    logic [13:0] out_q[$];
    logic [13:0] exp_q[$];

    stream_frame_aligner #(.DEPTH(4), .FRAME_PIXELS(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .sop_in(sop_in),
        .eop_in(eop_in), .valid_in(valid_in), .ready_out(ready_out),
        .ready_in(ready_in), .data_out(data_out), .sop_out(sop_out),
        .eop_out(eop_out), .valid_out(valid_out), .frame_count(frame_count),
        .short_err(short_err), .long_err(long_err)
    );

    always #5 clk = ~clk;

    // Record popped beats and error pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset && valid_out && ready_in) out_q.push_back({data_out, sop_out, eop_out});
        if (short_err) short_cnt++;
        if (long_err) long_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic send(input logic [11:0] d, input logic s, input logic e);
        logic ok;
        ok = 1'b0;
        data_in  = d;
        sop_in   = s;
        eop_in   = e;
        valid_in = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = ready_out;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_beat(input logic [11:0] d, input logic s, input logic e);
        exp_q.push_back({d, s, e});
    endtask

    task automatic drain_and_compare(input string tag);
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_counts();
        short_cnt = 0;
        long_cnt  = 0;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; data_in = '0; sop_in = 1'b0; eop_in = 1'b0; ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_out", ready_out, 1'b0);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_frame_count", frame_count, 16'd0);
        check("rst_errs", {short_err, long_err}, 2'b00);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_ready_out", ready_out, 1'b1);

        // Clean frame, with first-beat latency check.
        clear_counts();
        send(12'h100, 1'b1, 1'b0);
        check("lat_valid", valid_out, 1'b1);
        check("lat_head", {data_out, sop_out, eop_out}, {12'h100, 1'b1, 1'b0});
        expect_beat(12'h100, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            send(12'h100 + 12'(i), 1'b0, i == 7);
            expect_beat(12'h100 + 12'(i), 1'b0, i == 7);
        end
        drain_and_compare("clean");
        check("clean_frames", frame_count, 16'd1);
        check("clean_errs", short_cnt + long_cnt, 0);

        // Garbage before sop is consumed and dropped.
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("garb_ready%0d", i), ready_out, 1'b1);
            send(12'hbad, 1'b0, i == 2);
        end
        for (int i = 0; i < 8; i++) begin
            send(12'h200 + 12'(i), i == 0, i == 7);
            expect_beat(12'h200 + 12'(i), i == 0, i == 7);
        end
        drain_and_compare("garb");
        check("garb_frames", frame_count, 16'd2);
        check("garb_errs", short_cnt + long_cnt, 0);

        // Short frame: eop on beat 4.
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            send(12'h300 + 12'(i), i == 0, i == 4);
            expect_beat(12'h300 + 12'(i), i == 0, i == 4);
        end
        drain_and_compare("short");
        check("short_pulses", short_cnt, 1);
        check("short_long", long_cnt, 0);
        check("short_frames", frame_count, 16'd3);

        // Long frame: 10 beats, no eop; eop forced on 8th, last two dropped.
        clear_counts();
        for (int i = 0; i < 10; i++) send(12'h400 + 12'(i), i == 0, 1'b0);
        for (int i = 0; i < 8; i++) expect_beat(12'h400 + 12'(i), i == 0, i == 7);
        drain_and_compare("long");
        check("long_pulses", long_cnt, 1);
        check("long_short", short_cnt, 0);
        check("long_frames", frame_count, 16'd4);

        // Back-pressure: FIFO fills after 4 accepts, head held stable.
        clear_counts();
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) send(12'h500 + 12'(i), i == 0, 1'b0);
        for (int i = 0; i < 8; i++) expect_beat(12'h500 + 12'(i), i == 0, i == 7);
        data_in = 12'h504; sop_in = 1'b0; eop_in = 1'b0; valid_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp_ready%0d", c), ready_out, 1'b0);
            check($sformatf("bp_head%0d", c), {valid_out, data_out, sop_out, eop_out},
                  {1'b1, 12'h500, 1'b1, 1'b0});
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        for (int i = 4; i < 8; i++) send(12'h500 + 12'(i), 1'b0, i == 7);
        drain_and_compare("bp");
        check("bp_frames", frame_count, 16'd5);
        check("bp_errs", short_cnt + long_cnt, 0);

        // Reset mid-frame after 5 accepted beats, 3 still buffered.
        for (int i = 0; i < 5; i++) begin
            if (i == 2) ready_in = 1'b0;
            send(12'h600 + 12'(i), i == 0, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_in = 1'b1;
        check("mid_rst_valid", valid_out, 1'b0);
        check("mid_rst_frames", frame_count, 16'd0);
        out_q.delete();
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            send(12'h700 + 12'(i), i == 0, i == 7);
            expect_beat(12'h700 + 12'(i), i == 0, i == 7);
        end
        drain_and_compare("post_rst");
        check("post_rst_frames", frame_count, 16'd1);
        check("post_rst_errs", short_cnt + long_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stream_frame_aligner.md
Name: stream_frame_aligner

Overview:
- Downstream neighbour of the filter selection stage: consumes the selected filter's 12-bit pixel stream (sop/eop/valid/ready) and re-emits it frame-aligned towards the display output path.
- Discards pixels until a start-of-frame, enforces a fixed frame length, and regenerates eop from its own pixel counter.
- Flags short and long frames.
- Absorbs downstream back-pressure in a small show-ahead FIFO.

Parameters:
- DEPTH, 16, FIFO entries (power of two, >=2).
- FRAME_PIXELS, 307200, pixels per frame (640x480).
- CNT_W, 19, pixel counter width; must satisfy 2^CNT_W > FRAME_PIXELS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  12  pixel from filter stage.
- sop_in  in  1  start of frame.
- eop_in  in  1  end of frame.
- valid_in  in  1  upstream beat valid.
- ready_out  out  1  back-pressure to upstream.
- ready_in  in  1  back-pressure from downstream.
- data_out  out  12  pixel to downstream.
- sop_out  out  1  start of frame.
- eop_out  out  1  end of frame (regenerated).
- valid_out  out  1  output beat valid.
- frame_count  out  16  completed frames popped, wraps at 65535 -> 0.
- short_err  out  1  one-cycle pulse: frame ended early.
- long_err  out  1  one-cycle pulse: frame over-ran.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
  - Reset: FIFO empty, state SEEK, pixel count 0, frame_count 0.
  - Reset outputs: valid_out=0, short_err=0, long_err=0, ready_out=0.
  - Reset mid-frame drops all buffered data; no partial frame is emitted afterwards.
- Handshake:
  - ready_out = !full && !reset, in every state.
  - Beat accepted when valid_in && ready_out.
  - Beat popped when valid_out && ready_in.
  - valid_out = !empty (show-ahead). data_out/sop_out/eop_out reflect the FIFO head and are held stable while valid_out && !ready_in.
- Latency: a beat accepted in cycle N is on the outputs in cycle N+1 if the FIFO was empty.
- FIFO:
  - Entry is {data, sop, eop}, 14 bits.
  - Push and pop in the same cycle is allowed when not full and not empty; occupancy is unchanged.
  - When full, push is blocked even if a pop occurs that cycle (ready_out is not a function of ready_in).
  - Pointers wrap modulo DEPTH. Full/empty are determined by an occupancy counter of width log2(DEPTH)+1.
- FSM (on accepted beats only):
  - SEEK:
    - Beat with sop_in=0 is discarded (consumed, not written).
    - Beat with sop_in=1 is written with sop=1. count<=1 and go to PASS. If FRAME_PIXELS==1, it is instead written with eop=1 and the state stays SEEK.
  - PASS, accepted beat with sop_in=1:
    - Premature new frame: short_err pulse next cycle.
    - Beat is written with sop=1, count<=1, state stays PASS.
    - The previous frame is emitted without eop.
  - PASS, accepted beat with count==FRAME_PIXELS-1:
    - Written with eop=1 regardless of eop_in. count<=0, go to SEEK.
    - If eop_in=0, long_err pulses next cycle; subsequent non-sop beats are discarded in SEEK.
  - PASS, accepted beat with eop_in=1 and count<FRAME_PIXELS-1:
    - Written with eop=1. short_err pulse, count<=0, go to SEEK.
  - PASS, otherwise: written with sop=0, eop=0; count<=count+1.
  - sop_in and eop_in set together on one beat in PASS: treated as premature sop (sop rule takes priority); eop_in is ignored.
- frame_count increments on each pop whose entry has eop=1.
- Error pulses: short_err/long_err are registered, high exactly one cycle per event, never both in the same cycle.

Test Plan (FRAME_PIXELS=8, DEPTH=4):
- Clean frame: sop at beat 0, eop at beat 7, ready_in=1 -> 8 beats out, sop_out on the 1st, eop_out on the 8th, 1-cycle latency; frame_count=1; no error pulses.
- Pre-sop garbage: 3 beats with sop_in=0, then a clean frame -> garbage discarded (ready_out=1 throughout); output is exactly the 8 frame beats.
- Short frame: eop_in on beat 4 -> 5 beats out, eop_out on the 5th; short_err pulses once; frame_count=1.
- Long frame: 10 beats, no eop_in -> eop_out forced on the 8th beat; long_err pulses once; beats 9-10 discarded.
- Back-pressure: ready_in=0 while streaming -> ready_out drops after 4 accepts; head beat held stable; on ready_in=1 all 8 beats emerge in order, none lost or duplicated.
- Reset mid-frame after 5 accepted beats -> valid_out=0 next cycle, frame_count=0; the following clean frame is output intact.
